// File: rtl/bch_15_7_serial_decoder_if.sv
// Handshake bundle for the bit-serial BCH(15,7) decoder.
// Both channels use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; the sender keeps valid and its data
// steady until that edge, and ready may depend on the receiver's state only.
interface bch_15_7_serial_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_msg;
  logic [1:0] out_err_cnt;
  logic       out_uncorrectable;

  // Producer of codeword bits and consumer of results.
  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_msg, out_err_cnt, out_uncorrectable
  );

  // The decoder itself.
  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_msg, out_err_cnt, out_uncorrectable
  );
endinterface

// File: rtl/bch_15_7_serial_decoder.sv
// Bit-serial BCH(15,7,t=2) decoder over GF(16), x^4+x+1.
// Receives 15 bits MSB first, builds S1/S3 by Horner accumulation, solves the
// degree<=2 locator in one cycle, runs a 15-cycle Chien search, and presents
// the corrected message with an error count or an uncorrectable flag.
// Optional feature: define BCH_DEC_EARLY_EXIT_EN to skip the Chien search
// when both syndromes are zero (output values unchanged, result ready sooner).
module bch_15_7_serial_decoder (
  input  logic                           clk,
  input  logic                           rst,
  bch_15_7_serial_decoder_if.slave       bus,
  output logic [1:0]                     dbg_state
);

  typedef enum logic [1:0] {
    RECV   = 2'd0,
    LOCATE = 2'd1,
    CHIEN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nx;

  // Multiply by alpha in polynomial basis: x^4 folds back to x+1.
  function automatic logic [3:0] mul_a(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] mul_a2(input logic [3:0] x);
    return mul_a(mul_a(x));
  endfunction

  function automatic logic [3:0] mul_a3(input logic [3:0] x);
    return mul_a(mul_a(mul_a(x)));
  endfunction

  // Discrete log base alpha; the zero entry is never consulted.
  function automatic logic [3:0] gf_log(input logic [3:0] x);
    logic [3:0] r;
    case (x)
      4'h1:    r = 4'd0;
      4'h2:    r = 4'd1;
      4'h3:    r = 4'd4;
      4'h4:    r = 4'd2;
      4'h5:    r = 4'd8;
      4'h6:    r = 4'd5;
      4'h7:    r = 4'd10;
      4'h8:    r = 4'd3;
      4'h9:    r = 4'd14;
      4'ha:    r = 4'd9;
      4'hb:    r = 4'd7;
      4'hc:    r = 4'd6;
      4'hd:    r = 4'd13;
      4'he:    r = 4'd11;
      4'hf:    r = 4'd12;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  // alpha^e for e in 0..14.
  function automatic logic [3:0] gf_alog(input logic [3:0] e);
    logic [3:0] r;
    case (e)
      4'd0:    r = 4'h1;
      4'd1:    r = 4'h2;
      4'd2:    r = 4'h4;
      4'd3:    r = 4'h8;
      4'd4:    r = 4'h3;
      4'd5:    r = 4'h6;
      4'd6:    r = 4'hc;
      4'd7:    r = 4'hb;
      4'd8:    r = 4'h5;
      4'd9:    r = 4'ha;
      4'd10:   r = 4'h7;
      4'd11:   r = 4'he;
      4'd12:   r = 4'hf;
      4'd13:   r = 4'hd;
      4'd14:   r = 4'h9;
      default: r = 4'h1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] mod15(input logic [5:0] v);
    return 4'(v % 6'd15);
  endfunction

  // Datapath state.
  logic [14:0] recv;        // raw received word, never modified by correction
  logic [3:0]  s1;
  logic [3:0]  s3;
  logic [3:0]  cnt;         // beat index in RECV, bit position in CHIEN
  logic [3:0]  t1;
  logic [3:0]  t2;
  logic [1:0]  degree;
  logic        unc_flag;
  logic [1:0]  root_cnt;
  logic [6:0]  flip_mask;   // message-bit corrections found so far

  // Registered outputs.
  logic        out_valid_q;
  logic [6:0]  out_msg_q;
  logic [1:0]  out_err_cnt_q;
  logic        out_unc_q;

  // Combinational helpers.
  logic        beat;
  logic [3:0]  s1_cube;
  logic [3:0]  num;
  logic [3:0]  sigma2;
  logic        loc_unc;
  logic [1:0]  degree_nx;
  logic [3:0]  eval;
  logic        root_now;
  logic [1:0]  root_total;
  logic [6:0]  mask_total;
  logic        correctable;
  logic        syn_zero;

  assign bus.in_ready          = (state == RECV);
  assign bus.out_valid         = out_valid_q;
  assign bus.out_msg           = out_msg_q;
  assign bus.out_err_cnt       = out_err_cnt_q;
  assign bus.out_uncorrectable = out_unc_q;
  assign dbg_state             = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RECV;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    beat     = 1'b0;
    case (state)
      RECV: begin
        beat = bus.in_valid;
        if (beat && cnt == 4'd14) state_nx = LOCATE;
      end
      LOCATE: begin
        state_nx = CHIEN;
`ifdef BCH_DEC_EARLY_EXIT_EN
        if (syn_zero) state_nx = DONE;
`endif
      end
      CHIEN: begin
        if (cnt == 4'd0) state_nx = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nx = RECV;
      end
      default: state_nx = RECV;
    endcase
  end

  // Locator solve: sigma1 = S1, sigma2 = (S3 + S1^3) / S1.
  always_comb begin
    s1_cube  = 4'h0;
    num      = 4'h0;
    sigma2   = 4'h0;
    syn_zero = (s1 == 4'h0) && (s3 == 4'h0);
    loc_unc  = (s1 == 4'h0) && (s3 != 4'h0);
    if (s1 != 4'h0) begin
      s1_cube = gf_alog(mod15({2'b00, gf_log(s1)} * 6'd3));
      num     = s3 ^ s1_cube;
      if (num != 4'h0)
        sigma2 = gf_alog(mod15({2'b00, gf_log(num)} + 6'd15 - {2'b00, gf_log(s1)}));
    end
    if (sigma2 != 4'h0)  degree_nx = 2'd2;
    else if (s1 != 4'h0) degree_nx = 2'd1;
    else                 degree_nx = 2'd0;
  end

  // Chien step: root test at the current position and the running totals
  // that include it, so the final cycle can decide without an extra stage.
  always_comb begin
    eval       = 4'h1 ^ t1 ^ t2;
    root_now   = (eval == 4'h0);
    root_total = root_cnt + {1'b0, root_now};
    mask_total = flip_mask;
    if (root_now && cnt[3]) mask_total = flip_mask ^ (7'b1 << cnt[2:0]);
    correctable = !unc_flag && (root_total == degree);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      recv          <= 15'h0;
      s1            <= 4'h0;
      s3            <= 4'h0;
      cnt           <= 4'd0;
      t1            <= 4'h0;
      t2            <= 4'h0;
      degree        <= 2'd0;
      unc_flag      <= 1'b0;
      root_cnt      <= 2'd0;
      flip_mask     <= 7'h0;
      out_valid_q   <= 1'b0;
      out_msg_q     <= 7'h0;
      out_err_cnt_q <= 2'd0;
      out_unc_q     <= 1'b0;
    end else begin
      case (state)
        RECV: begin
          if (beat) begin
            recv <= {recv[13:0], bus.in_bit};
            s1   <= mul_a(s1)  ^ {3'b000, bus.in_bit};
            s3   <= mul_a3(s3) ^ {3'b000, bus.in_bit};
            cnt  <= (cnt == 4'd14) ? 4'd0 : cnt + 4'd1;
          end
        end
        LOCATE: begin
          t1        <= mul_a(s1);
          t2        <= mul_a2(sigma2);
          degree    <= degree_nx;
          unc_flag  <= loc_unc;
          root_cnt  <= 2'd0;
          flip_mask <= 7'h0;
          cnt       <= 4'd14;
`ifdef BCH_DEC_EARLY_EXIT_EN
          if (syn_zero) begin
            out_valid_q   <= 1'b1;
            out_msg_q     <= recv[14:8];
            out_err_cnt_q <= 2'd0;
            out_unc_q     <= 1'b0;
          end
`endif
        end
        CHIEN: begin
          t1        <= mul_a(t1);
          t2        <= mul_a2(t2);
          root_cnt  <= root_total;
          flip_mask <= mask_total;
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_valid_q <= 1'b1;
            if (correctable) begin
              out_msg_q     <= recv[14:8] ^ mask_total;
              out_err_cnt_q <= degree;
              out_unc_q     <= 1'b0;
            end else begin
              out_msg_q     <= recv[14:8];
              out_err_cnt_q <= 2'd0;
              out_unc_q     <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            s1          <= 4'h0;
            s3          <= 4'h0;
            cnt         <= 4'd0;
            degree      <= 2'd0;
            unc_flag    <= 1'b0;
            root_cnt    <= 2'd0;
            flip_mask   <= 7'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_15_7_serial_decoder.sv
// Bench for bch_15_7_serial_decoder: directed test-plan words plus random
// words with 0..4 bit errors, checked against a brute-force nearest-codeword
// reference decoder through an expected-result queue.
module tb_bch_15_7_serial_decoder;

  localparam logic [8:0] GEN = 9'b111010001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int last_t    = 0;
  int n_pushed  = 0;
  int n_results = 0;
  bit prev_valid = 1'b0;

  logic [9:0] exp_q[$];   // {msg, err_cnt, uncorrectable}
  int         lat_q[$];   // cycle in which out_valid must first rise

  bch_15_7_serial_decoder_if bus();

  bch_15_7_serial_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [14:0] encode(input logic [6:0] m);
    logic [14:0] v;
    v = {m, 8'h00};
    for (int i = 14; i >= 8; i--)
      if (v[i]) v = v ^ (15'(GEN) << (i - 8));
    return {m, v[7:0]};
  endfunction

  // Nearest codeword by exhaustive search; {is_codeword, msg, err, unc}.
  function automatic logic [10:0] ref_decode(input logic [14:0] r);
    int         best;
    int         d;
    logic [6:0] best_m;
    best   = 99;
    best_m = 7'h0;
    for (int m = 0; m < 128; m++) begin
      d = $countones(r ^ encode(7'(m)));
      if (d < best) begin
        best   = d;
        best_m = 7'(m);
      end
    end
    if (best <= 2) return {(best == 0), best_m, 2'(best), 1'b0};
    return {1'b0, r[14:8], 2'd0, 1'b1};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_msg"},   32'(bus.out_msg), 32'd0);
    check({tag, "_err_cnt"},   32'(bus.out_err_cnt), 32'd0);
    check({tag, "_unc"},       32'(bus.out_uncorrectable), 32'd0);
    check({tag, "_state"},     32'(dbg_state), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (!prev_valid) begin
          if (lat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL latency: out_valid rose at cycle %0d, expected no result", cyc);
          end else begin
            check("latency", 32'(cyc), 32'(lat_q.pop_front()));
          end
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result: unexpected result msg 0x%0h, expected none", bus.out_msg);
        end else begin
          check("out_msg", 32'(bus.out_msg), 32'(exp_q[0][9:3]));
          check("out_err_cnt", 32'(bus.out_err_cnt), 32'(exp_q[0][2:1]));
          check("out_uncorrectable", 32'(bus.out_uncorrectable), 32'(exp_q[0][0]));
          check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            n_results++;
          end
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_beat(input logic b);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: in_ready 0 after %0d cycles, expected 1", guard);
    end
    last_t = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [14:0] w, input int nbeats, input int gap4,
                           input int gap10, input bit rnd, input bit has_exp,
                           input logic [9:0] exp_val);
    logic [10:0] ref_out;
    int          gap;
    @(posedge clk);
    #1;
    for (int i = 0; i < nbeats; i++) begin
      drive_beat(w[14-i]);
      if (i == 4)       gap = gap4;
      else if (i == 10) gap = gap10;
      else if (rnd)     gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      else              gap = 0;
      if (i != nbeats - 1)
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
    end
    if (nbeats == 15) begin
      ref_out = ref_decode(w);
      exp_q.push_back(has_exp ? exp_val : ref_out[9:0]);
`ifdef BCH_DEC_EARLY_EXIT_EN
      lat_q.push_back(last_t + (ref_out[10] ? 2 : 17));
`else
      lat_q.push_back(last_t + 17);
`endif
      n_pushed++;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [14:0] w;
    logic [14:0] e;
    int          k;
    int          guard;

    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst_during");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_after");

    // Directed words from the test plan.
    send_word(15'h01D1, 15, 0, 0, 1'b0, 1'b1, {7'h01, 2'd0, 1'b0});
    wait_idle();
    send_word(15'h41D1, 15, 0, 0, 1'b0, 1'b1, {7'h01, 2'd1, 1'b0});
    wait_idle();
    send_word(15'h03D5, 15, 0, 0, 1'b0, 1'b1, {7'h01, 2'd2, 1'b0});
    wait_idle();
    send_word(15'h0000, 15, 3, 3, 1'b0, 1'b1, {7'h00, 2'd0, 1'b0});
    wait_idle();
    // Three errors: beyond correction capability.
    send_word(15'h01D1 ^ 15'h0007, 15, 0, 0, 1'b0, 1'b0, 10'h0);
    wait_idle();

    // Result backpressure with ignored in_valid pulses.
    bus.out_ready = 1'b0;
    send_word(15'h41D1, 15, 0, 0, 1'b0, 1'b1, {7'h01, 2'd1, 1'b0});
    guard = 0;
    @(negedge clk);
    while (!bus.out_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      if (i < 4) begin
        bus.in_valid = (i != 1);
        bus.in_bit   = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    check("bp_out_valid_after", 32'(bus.out_valid), 32'd0);
    wait_idle();
    // A leaked pulse would corrupt this word.
    send_word(15'h01D1, 15, 0, 0, 1'b0, 1'b1, {7'h01, 2'd0, 1'b0});
    wait_idle();

    // Reset in the middle of a word, with in_valid high during reset.
    send_word(15'h41D1, 7, 0, 0, 1'b0, 1'b0, 10'h0);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid_rst_during");
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_rst_after");
    k = n_results;
    send_word(15'h01D1, 15, 0, 0, 1'b0, 1'b1, {7'h01, 2'd0, 1'b0});
    wait_idle();
    repeat (20) @(negedge clk);
    check("mid_rst_one_result", 32'(n_results - k), 32'd1);

    // Random words with random errors and random input gaps.
    for (int n = 0; n < 40; n++) begin
      w = encode(7'($urandom_range(0, 127)));
      e = 15'h0;
      k = $urandom_range(0, 4);
      while ($countones(e) < k) e[$urandom_range(0, 14)] = 1'b1;
      send_word(w ^ e, 15, 0, 0, 1'b1, 1'b0, 10'h0);
    end
    wait_idle();
    repeat (25) @(negedge clk);

    check("result_count", 32'(n_results), 32'(n_pushed));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
